// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with sticky overflow/underflow and status flags.
// Define PARAM_FIFO_FWFT_EN for show-ahead output; otherwise o_data is a registered read port.
module param_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wren,
    input  logic                    rden,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [$clog2(DEPTH):0]  usedw,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_mem_we;

    // Flags decode from the registered count only, so no input reaches them combinationally.
    always_comb begin
        full         = (r_count == LP_DEPTH);
        empty        = (r_count == '0);
        almost_full  = (r_count >= LP_AF);
        almost_empty = (r_count <= LP_AE);
        usedw        = r_count;
        overflow     = r_ovf;
        underflow    = r_udf;
    end

    always_comb begin
        w_wr_acc = wren && !full && !clr;
        w_rd_acc = rden && !empty && !clr;
        w_mem_we = w_wr_acc && rst_n;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wren && full) begin
                r_ovf <= 1'b1;
            end
            if (rden && empty) begin
                r_udf <= 1'b1;
            end
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    always_comb begin
        o_data = empty ? '0 : r_mem[r_rd_ptr];
    end
`else
    logic [DATA_WIDTH-1:0] r_odata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_odata <= '0;
        end else if (clr) begin
            r_odata <= '0;
        end else if (w_rd_acc) begin
            r_odata <= r_mem[r_rd_ptr];
        end
    end

    always_comb begin
        o_data = r_odata;
    end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (DEPTH=8, DATA_WIDTH=8); follows PARAM_FIFO_FWFT_EN.
module tb_param_fifo;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wren;
    logic       rden;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [3:0] usedw;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    param_fifo #(
        .DEPTH      (8),
        .DATA_WIDTH (8),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wren         (wren),
        .rden         (rden),
        .i_data       (i_data),
        .o_data       (o_data),
        .usedw        (usedw),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        wren   = w;
        rden   = r;
        clr    = c;
        i_data = d;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
        clr  = 1'b0;
    endtask

    // Read (optionally with a simultaneous write); head is visible before the edge in
    // show-ahead mode and after the edge in registered mode.
    task automatic rd_chk(input string tag, input logic w, input logic [7:0] d, input logic [7:0] exp);
`ifdef PARAM_FIFO_FWFT_EN
        check(tag, o_data, exp);
        step(w, 1'b1, 1'b0, d);
`else
        step(w, 1'b1, 1'b0, d);
        check(tag, o_data, exp);
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        check("rst_odata", o_data, 0);
        rst_n = 1'b1;

        // Fill 0x01..0x08 and watch the threshold flags track the count.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            check("fill_usedw", usedw, i);
            check("fill_af", almost_full, (i >= 6) ? 1 : 0);
            check("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
        end
        check("fill_full", full, 1);
        for (int i = 1; i <= 8; i++) begin
            rd_chk("drain_data", 1'b0, 8'h00, 8'(i));
            check("drain_usedw", usedw, 8 - i);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);

        // Full with simultaneous write+read: read wins, write rejected, overflow sticks.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
        rd_chk("ovf_data", 1'b1, 8'hFF, 8'h11);
        check("ovf_usedw", usedw, 7);
        check("ovf_flag", overflow, 1);
        check("ovf_full", full, 0);
        for (int i = 2; i <= 8; i++) rd_chk("ovf_drain", 1'b0, 8'h00, 8'h10 + 8'(i));
        check("ovf_sticky", overflow, 1);
        check("ovf_empty", empty, 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("ovf_clr", overflow, 0);

        // Empty with simultaneous read+write: write wins, read rejected, underflow sticks.
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        check("udf_flag", underflow, 1);
        check("udf_usedw", usedw, 1);
`ifdef PARAM_FIFO_FWFT_EN
        check("udf_showahead", o_data, 8'hA5);
`else
        check("udf_hold", o_data, 8'h00);
`endif
        rd_chk("udf_data", 1'b0, 8'h00, 8'hA5);
        check("udf_empty", empty, 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("udf_clr", underflow, 0);

        // Steady-state streaming across pointer wrap against a reference queue.
        q.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
            q.push_back(8'hC0 + 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            exp_d = q.pop_front();
            q.push_back(8'h30 + 8'(i * 7));
            rd_chk("wrap_data", 1'b1, 8'h30 + 8'(i * 7), exp_d);
            check("wrap_usedw", usedw, 3);
        end
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            rd_chk("wrap_tail", 1'b0, 8'h00, exp_d);
        end
        check("wrap_empty", empty, 1);

        // clr beats a same-cycle write and clears sticky flags.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("clr_pre_udf", underflow, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        check("clr_pre_usedw", usedw, 3);
        step(1'b1, 1'b0, 1'b1, 8'h77);
        check("clr_usedw", usedw, 0);
        check("clr_empty", empty, 1);
        check("clr_ae", almost_empty, 1);
        check("clr_udf", underflow, 0);
        check("clr_odata", o_data, 0);
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        rd_chk("clr_after", 1'b0, 8'h00, 8'h5A);

        // Asynchronous reset mid-cycle discards stored entries immediately.
        step(1'b1, 1'b0, 1'b0, 8'h21);
        step(1'b1, 1'b0, 1'b0, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("arst_usedw", usedw, 0);
        check("arst_empty", empty, 1);
        check("arst_odata", o_data, 0);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h99);
        check("arst_first_wr", usedw, 1);
        rd_chk("arst_data", 1'b0, 8'h00, 8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of storage entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter DATA_WIDTH, default 8: bits per entry, minimum 1.
REQ-003 Parameter AF_THRESH, default DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous and active-low.
REQ-007 clr  input  1: synchronous flush request.
REQ-008 wren  input  1: write request.
REQ-009 rden  input  1: read request.
REQ-010 i_data  input  DATA_WIDTH: write data, sampled on an accepted write.
REQ-011 o_data  output  DATA_WIDTH: read data.
REQ-012 usedw  output  $clog2(DEPTH)+1: current occupancy count, 0..DEPTH.
REQ-013 full, empty, almost_full, almost_empty  output  1 each: status flags.
REQ-014 overflow, underflow  output  1 each: sticky error flags.

Function
REQ-015 Storage SHALL be inferred RTL memory with write and read pointers of $clog2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-016 Write accepted = wren && !full; the entry is written at wr_ptr, and wr_ptr increments on the same edge.
REQ-017 Read accepted = rden && !empty; rd_ptr increments on the same edge.
REQ-018 Count update: +1 on write only, -1 on read only, and unchanged when both are accepted in the same cycle.
REQ-019 At full with wren && rden: write rejected, read accepted, count becomes DEPTH-1, and overflow sets.
REQ-020 At empty with wren && rden: read rejected, write accepted, count becomes 1, and underflow sets.
REQ-021 full = (usedw == DEPTH), empty = (usedw == 0), almost_full = (usedw >= AF_THRESH), almost_empty = (usedw <= AE_THRESH).
REQ-022 All flags SHALL be decoded from registered state only, with no combinational path from inputs to flags; flags reflect an accepted operation one edge later.
REQ-023 Overflow sets on wren && full, and underflow sets on rden && empty; both hold until clr or reset.
REQ-024 clr takes priority over wren and rden in the same cycle.
REQ-025 On clr: pointers and count go to 0, overflow and underflow go to 0, o_data goes to 0, and memory contents are not cleared.
REQ-026 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-027 rst_n low SHALL immediately and asynchronously force: pointers 0, usedw 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, o_data 0.
REQ-028 Deassertion of rst_n SHALL be synchronised externally; the block requires no extra recovery cycles and the first operation is accepted on the first edge after deassertion.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no partial write completes.

Configuration
REQ-030 Macro PARAM_FIFO_FWFT_EN, when undefined, selects normal mode: o_data is a register loaded with the head entry on an accepted read, giving one cycle read latency, and holds otherwise.
REQ-031 With PARAM_FIFO_FWFT_EN defined, the block runs in show-ahead mode: o_data presents the head entry whenever empty is 0, an accepted read advances to the next entry, o_data is 0 when empty, and latency from write to visibility is one edge.

Verification
REQ-032 Use DEPTH=8, DATA_WIDTH=8. Scenario: reset, then write 0x01..0x08 -> full=1, usedw=8, almost_full set at usedw=6, then 8 reads return 0x01..0x08 in order, and empty=1.
REQ-033 Scenario: with the FIFO full, pulse wren=1, rden=1 -> usedw=7, overflow=1, and the oldest entry is read.
REQ-034 Scenario: with the FIFO empty, pulse rden=1, wren=1 with i_data=0xA5 -> underflow=1, usedw=1, and the next read returns 0xA5.
REQ-035 Scenario: 20 interleaved write/read pairs across pointer wrap -> the data stream matches a reference queue and usedw is constant.
REQ-036 Scenario: write 3 entries, then assert clr together with wren -> usedw=0, empty=1, flags cleared, and the write is ignored.
REQ-037 Scenario: run the suite with and without PARAM_FIFO_FWFT_EN -> o_data latency is 0 after the head is valid in show-ahead mode, and 1 cycle after an accepted read in normal mode.
